// File: rtl/barcode_pkg.sv
// barcode_pkg: shared types and constants for the station barcode receiver.
//   bc_state_t   - decoder FSM states
//   ID_BITS      - number of data bits in a frame (station ID width)
//   VALID_PREFIX - required value of the two MSBs of an accepted ID
//   TIMEOUT_MULT - WAIT_FALL abort limit in bit periods (BARCODE_TIMEOUT_EN builds)
package barcode_pkg;

  localparam int         ID_BITS      = 8;
  localparam logic [1:0] VALID_PREFIX = 2'b00;
  localparam int         TIMEOUT_MULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_FALL,
    SAMPLE,
    CHECK
  } bc_state_t;

endpackage

// File: rtl/barcode_rx_bc_sync.sv
// bc_sync: multi-flop synchronizer for the raw barcode line plus a
// falling-edge detector on the synchronized value.
// Parameters:
//   SYNC_STAGES - number of metastability flops (2 or more)
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset (all flops preset to 1 = idle)
//   bc    in   raw asynchronous serial line
//   bc_s  out  synchronized line
//   fall  out  one-cycle strobe: previous bc_s was 1, current bc_s is 0
module bc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bc,
  output logic bc_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] meta_p0;
  logic                   bc_p1;

  // Presetting to 1 keeps a reset release from looking like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '1;
      bc_p1   <= 1'b1;
    end else begin
      meta_p0 <= {meta_p0[SYNC_STAGES-2:0], bc};
      bc_p1   <= meta_p0[SYNC_STAGES-1];
    end
  end

  assign bc_s = meta_p0[SYNC_STAGES-1];
  assign fall = bc_p1 & ~bc_s;

endmodule

// File: rtl/barcode_rx.sv
// barcode_rx: decodes the serial station barcode into an 8-bit station ID
// and offers it to the command controller over ID / ID_vld / clr_ID_vld.
// A low start pulse measures the bit period; each data bit starts on a
// falling edge and the line level one period later is the bit value, so a
// short low pulse reads as 1 and a long one as 0. MSB first.
// Parameters:
//   CNT_W       - width of period / sample counters
//   SYNC_STAGES - synchronizer depth on BC (2 or more)
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   BC         in   raw barcode line, idle high
//   clr_ID_vld in   consumer acknowledge, clears ID_vld
//   ID         out  last accepted station ID
//   ID_vld     out  ID holds an unconsumed valid ID
//   busy       out  a frame is being decoded
// Build option: define BARCODE_TIMEOUT_EN to abort a frame when no falling
// edge arrives within TIMEOUT_MULT bit periods while waiting for a bit.
module barcode_rx
  import barcode_pkg::*;
#(
  parameter int CNT_W       = 22,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               BC,
  input  logic               clr_ID_vld,
  output logic [ID_BITS-1:0] ID,
  output logic               ID_vld,
  output logic               busy
);

  localparam int BIT_W = $clog2(ID_BITS);

  bc_state_t          state, state_nxt;
  logic               bc_s, fall;
  logic [CNT_W-1:0]   period_cnt, period, smp_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [ID_BITS-1:0] shift;

  logic clr_period, inc_period, latch_period;
  logic clr_smp, inc_smp, do_sample, load_id;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  bc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .bc   (BC),
    .bc_s (bc_s),
    .fall (fall)
  );

`ifdef BARCODE_TIMEOUT_EN
  logic [CNT_W+1:0] to_cnt, to_limit;
  logic             timeout;

  assign to_limit = (CNT_W+2)'(TIMEOUT_MULT) * {2'b00, period};
  assign timeout  = (to_cnt >= to_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state == WAIT_FALL)
      to_cnt <= to_cnt + (CNT_W+2)'(1);
    else
      to_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    clr_period   = 1'b0;
    inc_period   = 1'b0;
    latch_period = 1'b0;
    clr_smp      = 1'b0;
    inc_smp      = 1'b0;
    do_sample    = 1'b0;
    load_id      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          clr_period = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        if (!bc_s) begin
          inc_period = 1'b1;
        end else begin
          latch_period = 1'b1;
          state_nxt    = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          clr_smp   = 1'b1;
          state_nxt = SAMPLE;
        end
`ifdef BARCODE_TIMEOUT_EN
        else if (timeout) begin
          state_nxt = IDLE;
        end
`endif
      end
      SAMPLE: begin
        // Falls seen here are ignored; only the period count matters.
        inc_smp = 1'b1;
        if (smp_cnt == period) begin
          do_sample = 1'b1;
          state_nxt = (bit_cnt == BIT_W'(ID_BITS-1)) ? CHECK : WAIT_FALL;
        end
      end
      CHECK: begin
        load_id   = (shift[ID_BITS-1 -: 2] == VALID_PREFIX);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      period     <= '0;
      smp_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
    end else begin
      if (clr_period)      period_cnt <= '0;
      else if (inc_period) period_cnt <= sat_inc(period_cnt);

      if (latch_period) begin
        period  <= period_cnt;
        bit_cnt <= '0;
      end

      if (clr_smp)      smp_cnt <= '0;
      else if (inc_smp) smp_cnt <= sat_inc(smp_cnt);

      if (do_sample) begin
        shift   <= {shift[ID_BITS-2:0], bc_s};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Handshake: a new load wins over a simultaneous acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID     <= '0;
      ID_vld <= 1'b0;
    end else begin
      if (load_id) begin
        ID     <= shift;
        ID_vld <= 1'b1;
      end else if (clr_ID_vld) begin
        ID_vld <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_barcode_rx.sv
module tb_barcode_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       BC = 1'b1;
  logic       clr_ID_vld = 1'b0;
  logic [7:0] ID;
  logic       ID_vld;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the consumer-visible handshake.
  logic [7:0] ref_id  = 8'h00;
  logic       ref_vld = 1'b0;

  barcode_rx #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BC        (BC),
    .clr_ID_vld(clr_ID_vld),
    .ID        (ID),
    .ID_vld    (ID_vld),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line encoding: bit value is the line level one period after the fall.
  // A 1 is a low of t/2, a 0 is a low of 3t/2, each bit slot is 2t.
  function automatic int low_len(input bit b, input int t);
    return b ? t / 2 : (3 * t) / 2;
  endfunction

  task automatic send(input logic [7:0] id, input int start_low, input int t,
                      input int nbits, input bit glitch);
    BC = 1'b0; cyc(start_low);
    BC = 1'b1; cyc(t);
    for (int i = 0; i < nbits; i++) begin
      bit b;
      int low;
      b   = id[7-i];
      low = low_len(b, t);
      BC  = 1'b0;
      if (glitch && b) begin
        cyc(t / 4); BC = 1'b1; cyc(3); BC = 1'b0; cyc(low - t / 4 - 3);
      end else begin
        cyc(low);
      end
      BC = 1'b1;
      cyc(2 * t - low);
      if (i == 3) check("busy_mid", busy, 1);
    end
  endtask

  // Final data bit, watching for the end of decode; optionally holds the
  // acknowledge asserted across the whole decode of this bit.
  task automatic last_bit(input bit b, input int t, input bit hold_clr, output int lat);
    int low;
    low = low_len(b, t);
    BC = 1'b0;
    clr_ID_vld = hold_clr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == low) BC = 1'b1;
    end while (busy && lat < 1000);
    clr_ID_vld = 1'b0;
    check("done_bound", lat < 1000, 1);
    if (lat < low) cyc(low - lat);
    BC = 1'b1;
    cyc(t);
  endtask

  task automatic expect_frame(input logic [7:0] id, input string tag);
    if (id[7:6] == 2'b00) begin
      ref_id  = id;
      ref_vld = 1'b1;
    end
    cyc(2);
    check({tag, "_id"}, ID, ref_id);
    check({tag, "_vld"}, ID_vld, ref_vld);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic ack_pulse(input string tag);
    clr_ID_vld = 1'b1;
    @(negedge clk);
    clr_ID_vld = 1'b0;
    ref_vld = 1'b0;
    check({tag, "_vld"}, ID_vld, 0);
    check({tag, "_id"}, ID, ref_id);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    ref_id  = 8'h00;
    ref_vld = 1'b0;
    check("rst_id", ID, 0);
    check("rst_vld", ID_vld, 0);
    check("rst_busy", busy, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
  endtask

  initial begin
    int lat;
    logic [7:0] rid;
    int t;
    bit gl;

    cyc(2);
    apply_reset();
    check("idle_busy", busy, 0);

    // Invalid prefix from reset: nothing accepted.
    send(8'hC5, 100, 100, 8, 1'b0);
    expect_frame(8'hC5, "bad_c5");

    // Valid frame with end-of-decode latency measured from the last fall.
    send(8'h25, 100, 100, 7, 1'b0);
    last_bit(1'b1, 100, 1'b0, lat);
    check("lat_25", (lat >= 101 && lat <= 106), 1);
    check("vld_at_done", ID_vld, 1);
    expect_frame(8'h25, "f25");

    ack_pulse("ack25");
    ack_pulse("ack_idle");

    // Acknowledge held while the frame is accepted: set wins.
    send(8'h12, 100, 100, 7, 1'b0);
    last_bit(1'b0, 100, 1'b1, lat);
    check("coll_vld", ID_vld, 1);
    check("coll_id", ID, 8'h12);
    expect_frame(8'h12, "f12");

    // Overwrite while still valid.
    send(8'h0D, 100, 100, 8, 1'b0);
    expect_frame(8'h0D, "ovr");

    // Reset in the middle of a frame, then a clean frame.
    send(8'hA5, 100, 100, 3, 1'b0);
    apply_reset();
    send(8'h3F, 100, 100, 8, 1'b0);
    expect_frame(8'h3F, "f3f");

    // Glitches inside the sample window must not disturb decode.
    send(8'h2B, 100, 100, 8, 1'b1);
    expect_frame(8'h2B, "glitch");

    // Long start pulse saturates the 8-bit period counter at 255.
    send(8'h19, 300, 256, 8, 1'b0);
    expect_frame(8'h19, "sat");

    // Partial frame followed by a long idle high.
    ack_pulse("ack_pre_to");
    send(8'h2A, 100, 100, 4, 1'b0);
    BC = 1'b1;
    cyc(600);
`ifdef BARCODE_TIMEOUT_EN
    check("to_busy", busy, 0);
    check("to_vld", ID_vld, ref_vld);
    check("to_id", ID, ref_id);
`else
    check("nto_busy", busy, 1);
    apply_reset();
`endif
    send(8'h07, 100, 100, 8, 1'b0);
    expect_frame(8'h07, "f07");

    // Randomized frames, periods, glitches and acknowledges.
    for (int k = 0; k < 16; k++) begin
      rid = 8'($urandom);
      if ($urandom_range(0, 1) == 1) rid[7:6] = 2'b00;
      t  = $urandom_range(30, 80);
      gl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) ack_pulse("rnd_ack");
      send(rid, t, t, 8, gl);
      expect_frame(rid, "rnd");
      cyc($urandom_range(1, 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
